bus_fifo_param: RTL and testbench

Parametrised synchronous FIFO for the bus interface path. It buffers words from a producer (interface side) to a consumer (core side) with first-word-fall-through reads. It provides registered full/empty/almost-full/almost-empty flags, an occupancy count, sticky overflow/underflow error flags with a clear, and a synchronous flush. It replaces the fixed 32x16 bus buffer and is instantiable per channel with different width, depth and thresholds.

---
 rtl/bus_fifo_param_if.sv | 30 +++
 rtl/bus_fifo_param.sv | 86 ++++++++
 tb/tb_bus_fifo_param.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/bus_fifo_param_if.sv
// Producer/consumer bus bundle for bus_fifo_param.
// The "slave" modport is the FIFO side. The "master" modport is the side that drives writes and reads.
interface bus_fifo_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              clr_err;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en, clr_err,
    input  rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, clr_err,
    output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/bus_fifo_param.sv
// Parametrised first-word-fall-through synchronous FIFO for the bus interface path.
// All flags are registered from the next occupancy value. The storage array is not reset.
module bus_fifo_param #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input logic             clk,
  input logic             reset,
  bus_fifo_param_if.slave bus
);
  localparam int CW = ADDR_W + 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [CW-1:0] AF_TH  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AE_TH  = CW'(AEMPTY_TH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [CW-1:0] wp_q, wp_d, rp_q, rp_d, count_q, count_d;
  logic          full_q, full_d, empty_q, empty_d;
  logic          afull_q, afull_d, aempty_q, aempty_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          wr_acc, rd_acc;

  always_comb begin
    wr_acc = bus.wr_en & ~full_q  & ~bus.flush;
    rd_acc = bus.rd_en & ~empty_q & ~bus.flush;
    wp_d   = wp_q;
    rp_d   = rp_q;
    if (bus.flush) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (wr_acc) wp_d = wp_q + CW'(1);
      if (rd_acc) rp_d = rp_q + CW'(1);
    end
    // The wrap bit makes the pointer difference exact over 0..DEPTH.
    count_d  = wp_d - rp_d;
    full_d   = (count_d == CNT_FULL);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AF_TH);
    aempty_d = (count_d <= AE_TH);
    // A new error wins over clr_err. Flush masks requests, so it raises no error.
    ovf_d = (ovf_q & ~bus.clr_err) | (bus.wr_en & full_q  & ~bus.flush);
    udf_d = (udf_q & ~bus.clr_err) | (bus.rd_en & empty_q & ~bus.flush);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q     <= '0;
      rp_q     <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // No write is committed while reset is held.
  always_ff @(posedge clk) begin
    if (reset && wr_acc) mem_q[wp_q[ADDR_W-1:0]] <= bus.wr_data;
  end

  assign bus.rd_data      = empty_q ? '0 : mem_q[rp_q[ADDR_W-1:0]];
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_bus_fifo_param.sv
// Directed bench for bus_fifo_param with DEPTH=16, AFULL_TH=12 and AEMPTY_TH=2.
// Expected values are computed by hand from the FIFO behaviour.
module tb_bus_fifo_param;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bus_fifo_param_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  bus_fifo_param #(.DATA_W(32), .ADDR_W(4), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 0; bus.rd_en = 0; bus.flush = 0; bus.clr_err = 0;
  endtask

  initial begin
    idle();
    bus.wr_data = '0;
    #12;
    chk("rst_count", bus.count, 0);
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_ae", bus.almost_empty, 1);
    chk("rst_af", bus.almost_full, 0);
    chk("rst_ovf", bus.overflow, 0);
    chk("rst_udf", bus.underflow, 0);
    chk("rst_rdata", bus.rd_data, 0);
    #3 reset = 1;
    step();

    // Fill to full with 0x11..0x20. The head must stay 0x11.
    for (int i = 0; i < 16; i++) begin
      bus.wr_en = 1; bus.wr_data = 32'h11 + i;
      step();
      chk("fill_count", bus.count, i + 1);
      chk("fill_af", bus.almost_full, (i + 1) >= 12);
      chk("fill_full", bus.full, (i + 1) == 16);
      chk("fill_head", bus.rd_data, 32'h11);
    end

    // From full, a simultaneous write and read: the read is accepted and the write is dropped.
    bus.wr_en = 1; bus.rd_en = 1; bus.wr_data = 32'hAA;
    step();
    idle();
    chk("ovf_count", bus.count, 15);
    chk("ovf_set", bus.overflow, 1);
    chk("ovf_head", bus.rd_data, 32'h12);
    chk("ovf_full", bus.full, 0);
    bus.clr_err = 1;
    step();
    idle();
    chk("ovf_clr", bus.overflow, 0);
    for (int i = 0; i < 15; i++) begin
      chk("drain_data", bus.rd_data, 32'h12 + i);
      bus.rd_en = 1;
      step();
    end
    idle();
    chk("drain_empty", bus.empty, 1);
    chk("drain_rdata0", bus.rd_data, 0);

    // On empty, a simultaneous write and read: the write is accepted and underflow is set.
    // clr_err is held high in the same cycle, so this also checks that set wins.
    bus.wr_en = 1; bus.rd_en = 1; bus.wr_data = 32'h55; bus.clr_err = 1;
    step();
    idle();
    chk("udf_count", bus.count, 1);
    chk("udf_set", bus.underflow, 1);
    chk("udf_head", bus.rd_data, 32'h55);
    chk("udf_empty", bus.empty, 0);
    bus.clr_err = 1; bus.rd_en = 1;
    step();
    idle();
    chk("udf_clr", bus.underflow, 0);
    chk("udf_pop_empty", bus.empty, 1);

    // Streaming with a steady occupancy of 3 across pointer wrap.
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1; bus.wr_data = i;
      step();
      chk("strm_ae", bus.almost_empty, (i + 1) <= 2);
    end
    for (int i = 3; i < 40; i++) begin
      chk("strm_data", bus.rd_data, i - 3);
      bus.wr_en = 1; bus.rd_en = 1; bus.wr_data = i;
      step();
      chk("strm_count", bus.count, 3);
    end
    bus.wr_en = 0;
    for (int i = 37; i < 40; i++) begin
      chk("strm_tail", bus.rd_data, i);
      bus.rd_en = 1;
      step();
    end
    idle();
    chk("strm_ovf", bus.overflow, 0);
    chk("strm_udf", bus.underflow, 0);
    chk("strm_empty", bus.empty, 1);

    // Flush: requests are ignored and error flags survive.
    bus.rd_en = 1;
    step();
    idle();
    chk("fl_udf_pre", bus.underflow, 1);
    for (int i = 0; i < 5; i++) begin
      bus.wr_en = 1; bus.wr_data = 32'hA0 + i;
      step();
    end
    chk("fl_count_pre", bus.count, 5);
    bus.flush = 1; bus.wr_en = 1; bus.rd_en = 1; bus.wr_data = 32'hEE;
    step();
    idle();
    chk("fl_count", bus.count, 0);
    chk("fl_empty", bus.empty, 1);
    chk("fl_rdata", bus.rd_data, 0);
    chk("fl_ae", bus.almost_empty, 1);
    chk("fl_udf_kept", bus.underflow, 1);
    bus.wr_en = 1; bus.wr_data = 32'h77;
    step();
    idle();
    chk("fl_next_head", bus.rd_data, 32'h77);
    chk("fl_next_count", bus.count, 1);

    // Asynchronous reset in the middle of a burst, with no clock edge in between.
    bus.rd_en = 1;
    step();
    bus.rd_en = 1;
    step();
    idle();
    chk("ar_udf_pre", bus.underflow, 1);
    for (int i = 0; i < 7; i++) begin
      bus.wr_en = 1; bus.wr_data = 32'hC0 + i;
      step();
    end
    chk("ar_count_pre", bus.count, 7);
    #2 reset = 0;
    #1;
    chk("ar_count", bus.count, 0);
    chk("ar_empty", bus.empty, 1);
    chk("ar_ae", bus.almost_empty, 1);
    chk("ar_full", bus.full, 0);
    chk("ar_rdata", bus.rd_data, 0);
    chk("ar_udf", bus.underflow, 0);
    idle();
    #20;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
